// File: rtl/issue_scoreboard.sv
// issue_scoreboard: tracks in-flight rd writers in EX/MEM and stalls dependent decode instructions
module issue_scoreboard #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      dec_ir,
  input  logic             dec_valid,
  input  logic             flush,
  input  logic             pipe_hold,
  output logic             stall,
  output logic             pc_write,
  output logic             decode_en,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_count
);
  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic wr_rd, use1, use2, hit1, hit2, issue, unused_ir;
  logic ex_v_q, ex_v_d, mem_v_q, mem_v_d;
  logic [4:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign opc = dec_ir[6:0];
  assign rd = dec_ir[11:7];
  assign f3 = dec_ir[14:12];
  assign rs1 = dec_ir[19:15];
  assign rs2 = dec_ir[24:20];
  assign unused_ir = ^dec_ir[31:25];
  // classify the decode instruction: which sources it reads and whether it writes a nonzero rd
  always_comb begin
    wr_rd = 1'b0;
    use1 = 1'b0;
    use2 = 1'b0;
    case (opc)
      7'b0110111, 7'b0010111, 7'b1101111: wr_rd = 1'b1;
      7'b1100111, 7'b0000011, 7'b0010011: begin wr_rd = 1'b1; use1 = 1'b1; end
      7'b0110011: begin wr_rd = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      7'b1100011, 7'b0100011: begin use1 = 1'b1; use2 = 1'b1; end
      7'b1110011: begin wr_rd = f3 != 3'b000; use1 = (f3 != 3'b000) && !f3[2]; end
      default: ;
    endcase
    wr_rd = wr_rd & (rd != 5'd0);
  end
  assign hit1 = use1 & (rs1 != 5'd0) & ((ex_v_q & (ex_rd_q == rs1)) | (mem_v_q & (mem_rd_q == rs1)));
  assign hit2 = use2 & (rs2 != 5'd0) & ((ex_v_q & (ex_rd_q == rs2)) | (mem_v_q & (mem_rd_q == rs2)));
  assign stall = dec_valid & ~flush & (hit1 | hit2);
  assign pc_write = ~stall & ~pipe_hold;
  assign decode_en = pc_write;
  assign ex_bubble = stall | flush | ~dec_valid;
  assign issue = dec_valid & ~stall & ~flush;
  assign stall_count = cnt_q;
  // age records EX->MEM unless frozen; count non-held stall cycles, saturating
  always_comb begin
    ex_v_d = pipe_hold ? ex_v_q : issue & wr_rd;
    ex_rd_d = pipe_hold ? ex_rd_q : rd;
    mem_v_d = pipe_hold ? mem_v_q : ex_v_q;
    mem_rd_d = pipe_hold ? mem_rd_q : ex_rd_q;
    cnt_d = (stall & ~pipe_hold & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // slot and counter registers; reset clears every record
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_v_q <= 1'b0;
      ex_rd_q <= 5'd0;
      mem_v_q <= 1'b0;
      mem_rd_q <= 5'd0;
      cnt_q <= '0;
    end else begin
      ex_v_q <= ex_v_d;
      ex_rd_q <= ex_rd_d;
      mem_v_q <= mem_v_d;
      mem_rd_q <= mem_rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed checks of hazard detection, flush, hold, saturation and reset
module tb_issue_scoreboard;
  logic CLK = 1'b0, RST = 1'b1;
  logic [31:0] dec_ir = 32'h0;
  logic dec_valid = 1'b0, flush = 1'b0, pipe_hold = 1'b0;
  logic stall, pc_write, decode_en, ex_bubble;
  logic stall4, pc_write4, decode_en4, ex_bubble4;
  logic [15:0] cnt16;
  logic [3:0] cnt4;
  int total = 0, bad = 0;
  localparam logic [31:0] ADDI5 = 32'h00100293;
  localparam logic [31:0] ADD6 = 32'h00528333;
  localparam logic [31:0] LW7 = 32'h0000A383;
  localparam logic [31:0] ADDI8 = 32'h00000413;
  localparam logic [31:0] SW7 = 32'h00712223;
  localparam logic [31:0] ADDI0 = 32'h00500013;
  localparam logic [31:0] ADD1 = 32'h000000B3;
  localparam logic [31:0] BEQ = 32'h00208563;
  localparam logic [31:0] ADD11 = 32'h000505B3;
  localparam logic [31:0] ADD7 = 32'h000303B3;
  issue_scoreboard dut (
    .CLK(CLK), .RST(RST), .dec_ir(dec_ir), .dec_valid(dec_valid), .flush(flush),
    .pipe_hold(pipe_hold), .stall(stall), .pc_write(pc_write), .decode_en(decode_en),
    .ex_bubble(ex_bubble), .stall_count(cnt16)
  );
  issue_scoreboard #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .dec_ir(dec_ir), .dec_valid(dec_valid), .flush(flush),
    .pipe_hold(pipe_hold), .stall(stall4), .pc_write(pc_write4), .decode_en(decode_en4),
    .ex_bubble(ex_bubble4), .stall_count(cnt4)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [31:0] ir, input logic v, input logic fl, input logic h);
    dec_ir = ir;
    dec_valid = v;
    flush = fl;
    pipe_hold = h;
    #4;
  endtask
  task automatic adv;
    @(posedge CLK);
    #1;
  endtask
  task automatic idle2;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    adv();
    adv();
  endtask
  initial begin
    adv();
    adv();
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_stall", stall, 0);
    chk("rst_pcw", pc_write, 1);
    chk("rst_den", decode_en, 1);
    chk("rst_bub", ex_bubble, 1);
    chk("rst_cnt", cnt16, 0);
    RST = 1'b0;
    adv();
    drive(ADDI5, 1'b1, 1'b0, 1'b0);
    chk("d1_prod_stall", stall, 0);
    chk("d1_prod_bub", ex_bubble, 0);
    adv();
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    chk("d1_c1_stall", stall, 1);
    chk("d1_c1_bub", ex_bubble, 1);
    chk("d1_c1_pcw", pc_write, 0);
    adv();
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    chk("d1_c2_stall", stall, 1);
    chk("d1_c2_bub", ex_bubble, 1);
    adv();
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    chk("d1_c3_stall", stall, 0);
    chk("d1_c3_den", decode_en, 1);
    chk("d1_c3_bub", ex_bubble, 0);
    adv();
    chk("d1_cnt", cnt16, 2);
    idle2();
    drive(LW7, 1'b1, 1'b0, 1'b0);
    chk("d2_lw", stall, 0);
    adv();
    drive(ADDI8, 1'b1, 1'b0, 1'b0);
    chk("d2_mid", stall, 0);
    adv();
    drive(SW7, 1'b1, 1'b0, 1'b0);
    chk("d2_sw1", stall, 1);
    adv();
    drive(SW7, 1'b1, 1'b0, 1'b0);
    chk("d2_sw2", stall, 0);
    adv();
    chk("d2_cnt", cnt16, 3);
    idle2();
    drive(ADDI0, 1'b1, 1'b0, 1'b0);
    adv();
    drive(ADD1, 1'b1, 1'b0, 1'b0);
    chk("x0_dst", stall, 0);
    adv();
    idle2();
    drive(BEQ, 1'b1, 1'b0, 1'b0);
    chk("br_prod", stall, 0);
    adv();
    drive(ADD11, 1'b1, 1'b0, 1'b0);
    chk("br_nord", stall, 0);
    adv();
    chk("br_cnt", cnt16, 3);
    idle2();
    drive(ADDI5, 1'b1, 1'b0, 1'b0);
    adv();
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    chk("fl_pend", stall, 1);
    adv();
    drive(ADD6, 1'b1, 1'b1, 1'b0);
    chk("fl_stall", stall, 0);
    chk("fl_bub", ex_bubble, 1);
    chk("fl_pcw", pc_write, 1);
    adv();
    drive(ADD7, 1'b1, 1'b0, 1'b0);
    chk("fl_norec", stall, 0);
    adv();
    chk("fl_cnt", cnt16, 4);
    idle2();
    drive(ADDI5, 1'b1, 1'b0, 1'b0);
    adv();
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    chk("h_s1", stall, 1);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(ADD6, 1'b1, 1'b0, 1'b1);
      chk($sformatf("h_hold%0d_stall", i), stall, 1);
      chk($sformatf("h_hold%0d_pcw", i), pc_write, 0);
      adv();
    end
    chk("h_cnt_frozen", cnt16, 5);
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    chk("h_s5", stall, 1);
    adv();
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    chk("h_rel", stall, 0);
    adv();
    chk("h_cnt", cnt16, 6);
    idle2();
    for (int i = 0; i < 10; i++) begin
      drive(ADDI5, 1'b1, 1'b0, 1'b0);
      adv();
      drive(ADD6, 1'b1, 1'b0, 1'b0);
      adv();
      adv();
      adv();
    end
    chk("sat_cnt4", cnt4, 15);
    chk("sat_cnt16", cnt16, 26);
    idle2();
    drive(ADDI5, 1'b1, 1'b0, 1'b0);
    adv();
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    chk("rs_live", stall, 1);
    RST = 1'b1;
    adv();
    RST = 1'b0;
    drive(ADD6, 1'b1, 1'b0, 1'b0);
    chk("rs_stall", stall, 0);
    chk("rs_cnt16", cnt16, 0);
    chk("rs_cnt4", cnt4, 0);
    chk("rs_bub", ex_bubble, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Writeback-side issue scoreboard for the OTTER pipeline. It records the destination register of every instruction issued from decode, ages those records through the EX and MEM stages, and releases them when the instruction reaches writeback. Decode-stage source registers are checked against the live records: on a match, it holds PC and the decode register and injects a bubble into EX. It also keeps a saturating count of hazard stall cycles for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- CLK  in  1  pipeline clock
- RST  in  1  synchronous, active-high reset
- dec_ir  in  32  instruction currently held in the decode register
- dec_valid  in  1  dec_ir is a real instruction (not a bubble)
- flush  in  1  branch/jump resolved taken; the decode instruction is squashed this cycle
- pipe_hold  in  1  whole pipeline frozen this cycle (memory wait)
- stall  out  1  decode hazard; combinational
- pc_write  out  1  PC register enable
- decode_en  out  1  decode register enable
- ex_bubble  out  1  load NOP (32'h00000013) into the execute register instead of the decoded instruction
- stall_count  out  CNT_W  saturating count of hazard stall cycles

## Operation
- Decode of dec_ir:
  - opcode = dec_ir[6:0]; rd = [11:7]; rs1 = [19:15]; rs2 = [24:20]; funct3 = [14:12].
- Writes rd (when rd != 0):
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011, SYSTEM 1110011 with funct3 != 000.
- Uses rs1:
  - JALR, BRANCH 1100011, LOAD, STORE 0100011, OP-IMM, OP.
  - SYSTEM when funct3 != 000 and funct3[2] == 0.
- Uses rs2: BRANCH, STORE, OP.
- Register x0 never matches. Unknown opcodes use no sources and write no rd.
- Two record slots, each holding a valid bit and a 5-bit rd:
  - ex_slot is the instruction now in EX.
  - mem_slot is the instruction now in MEM.
- WB holds no slot. The register file is write-first, so an instruction in WB never causes a hazard.
- stall = dec_valid & ~flush & (hit1 | hit2):
  - hitN = source N is used & rsN != 0 & rsN matches a valid ex_slot or mem_slot.
- pc_write = decode_en = ~stall & ~pipe_hold.
- ex_bubble = stall | flush | ~dec_valid.
- issue = dec_valid & ~stall & ~flush. This is the only path by which a record is created.
- Slot update, on each rising CLK edge when pipe_hold == 0:
  - mem_slot <= ex_slot.
  - ex_slot <= {issue & writes_rd, rd}.
- When pipe_hold == 1, both slots hold their values.
- stall_count increments by 1 on each edge where stall & ~pipe_hold. It saturates at all-ones and never wraps.
- flush has priority over stall: a squashed instruction never stalls and never creates a record.

## Timing
- Reset (RST high at an edge): both slot valid bits 0, stall_count 0.
  - Output values during and after reset: stall 0, pc_write 1, decode_en 1, ex_bubble = ~dec_valid.
- RST is sampled at the edge and overrides pipe_hold and all other inputs. Asserting it mid-stall clears every record; the stall drops in the next cycle.
- stall/pc_write/decode_en/ex_bubble are combinational from dec_ir, dec_valid, flush, pipe_hold and the slots. There is no registered latency.
- Dependency distance d (cycles between producer and consumer entering decode) sets the number of stall cycles:
  - d = 1: 2 stall cycles (producer in EX, then in MEM).
  - d = 2: 1 stall cycle.
  - d >= 3: none.
- Cycles with pipe_hold do not age slots. Stall length in clock cycles grows by the number of hold cycles, but stall_count ignores those cycles.
- Producer and consumer may be the same register for both sources. One match is enough; the stall is not doubled.
- Back-to-back writers to the same rd: both slots can hold the same rd. A consumer stalls until both have left MEM.

## Test plan
- Reset, then send an `addi x5,x0,1` / `add x6,x5,x5` pair in consecutive decode cycles. Required: stall is high for exactly 2 cycles, ex_bubble is high for those cycles, and the add issues on the 3rd cycle. stall_count = 2.
- Producer `lw x7,0(x1)`, one unrelated instruction, then `sw x7,4(x2)` (rs2 dependency). Required: exactly 1 stall cycle. stall_count increments by 1.
- Destination x0: `addi x0,x0,5` then `add x1,x0,x0`. Required: no stall. A branch producer (no rd) followed by a reader of x[11:7] of the branch encoding: no stall.
- Stall pending with the dependent instruction in decode, then flush = 1 for one cycle. Required: stall is 0 in that cycle, ex_bubble = 1, and no record is created for the squashed instruction.
- d = 1 dependency with pipe_hold high for 3 cycles mid-stall. Required: slots frozen and pc_write = 0 during the hold; 5 stall-high cycles in total; stall_count = 2.
- With CNT_W = 4, force 20 stall cycles: stall_count stays at 15. Assert RST while a record is live: next cycle stall = 0 and stall_count = 0.
